// File: rtl/item_rle_encoder.sv
// rtl/item_rle_encoder.sv - streaming run-length encoder with output record FIFO
module item_rle_encoder #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] item_in,
    input  logic             item_valid,
    output logic             item_ready,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] run_value,
    output logic [LEN_W-1:0] run_len,
    output logic             run_valid,
    input  logic             run_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = {LEN_W{1'b1}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_val_q, cur_val_d;
    logic [LEN_W-1:0] cur_len_q, cur_len_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] val_mem_q [DEPTH];
    logic [LEN_W-1:0] len_mem_q [DEPTH];

    logic full;
    logic accept;
    logic pop;
    logic push;

    // item_ready comes only from registered occupancy, never from run_ready
    assign full       = (count_q == FULL_CNT);
    assign item_ready = !full;
    assign run_valid  = (count_q != '0);
    assign accept     = item_valid && item_ready;
    assign pop        = run_valid && run_ready;
    assign busy       = (state_q == ST_RUN);
    assign run_value  = run_valid ? val_mem_q[rd_ptr_q] : '0;
    assign run_len    = run_valid ? len_mem_q[rd_ptr_q] : '0;

    always_comb begin
        state_d   = state_q;
        cur_val_d = cur_val_q;
        cur_len_d = cur_len_q;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cur_val_d = item_in;
                    cur_len_d = LEN_W'(1);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if ((item_in == cur_val_q) && (cur_len_q != MAX_LEN)) begin
                        cur_len_d = cur_len_q + 1'b1;
                    end else begin
                        // close the current run and open a new one with this item
                        push      = 1'b1;
                        cur_val_d = item_in;
                        cur_len_d = LEN_W'(1);
                    end
                end else if (flush && !full) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_val_q <= '0;
            cur_len_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_val_q <= cur_val_d;
            cur_len_q <= cur_len_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            val_mem_q[wr_ptr_q] <= cur_val_q;
            len_mem_q[wr_ptr_q] <= cur_len_q;
        end
    end

endmodule

// File: tb/tb_item_rle_encoder.sv
// tb/tb_item_rle_encoder.sv - scoreboard bench for item_rle_encoder
module tb_item_rle_encoder;

    typedef struct {
        logic [7:0] v;
        logic [7:0] l;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] item_in;
    logic       item_valid;
    logic       item_ready;
    logic       flush;
    logic       busy;
    logic [7:0] run_value;
    logic [7:0] run_len;
    logic       run_valid;
    logic       run_ready;

    int checks = 0;
    int failures = 0;

    rec_t exp_q[$];
    bit   m_open;
    int   m_val;
    int   m_len;

    item_rle_encoder #(.WIDTH(8), .LEN_W(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .item_in(item_in), .item_valid(item_valid), .item_ready(item_ready),
        .flush(flush), .busy(busy),
        .run_value(run_value), .run_len(run_len), .run_valid(run_valid),
        .run_ready(run_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int v, input int l);
        rec_t r;
        r.v = 8'(v);
        r.l = 8'(l);
        exp_q.push_back(r);
    endtask

    // Reference: a run is a maximal group of equal consecutive accepted items,
    // capped at 255; it ends on a different item, on the cap, or on flush.
    task automatic step(input bit v, input int it, input bit fl);
        bit acc;
        item_valid = v;
        item_in    = 8'(it);
        flush      = fl;
        acc = v && (item_ready === 1'b1);
        if (acc) begin
            if (!m_open) begin
                m_open = 1;
                m_val  = it;
                m_len  = 1;
            end else if (it == m_val && m_len < 255) begin
                m_len++;
            end else begin
                push_exp(m_val, m_len);
                m_val = it;
                m_len = 1;
            end
        end else if (fl && m_open && (item_ready === 1'b1)) begin
            push_exp(m_val, m_len);
            m_open = 0;
        end
        @(posedge clk);
        #1;
        check("busy_vs_model", int'(busy), int'(m_open));
    endtask

    task automatic do_reset();
        item_valid = 0;
        flush      = 0;
        reset      = 1;
        exp_q.delete();
        m_open = 0;
        m_val  = 0;
        m_len  = 0;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic close_run();
        int n = 0;
        while (m_open && n < 50) begin
            step(0, 0, 1);
            n++;
        end
        check("flush_closed", int'(m_open), 0);
        item_valid = 0;
        flush      = 0;
    endtask

    task automatic drain();
        int n = 0;
        run_ready = 1;
        while ((exp_q.size() != 0 || run_valid) && n < 100) begin
            step(0, 0, 0);
            n++;
        end
        check("drain_exp_empty", exp_q.size(), 0);
        check("drain_run_valid", int'(run_valid), 0);
    endtask

    // Monitor: compares every record taken by the downstream against the scoreboard
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (run_valid !== 1'b1) begin
                checks++;
                if (run_value !== 8'd0 || run_len !== 8'd0) begin
                    failures++;
                    $display("FAIL idle_outputs: got value=%0d len=%0d expected 0 0", run_value, run_len);
                end
            end else if (run_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_record: got (%0d,%0d) expected none", run_value, run_len);
                end else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    if (run_value !== e.v || run_len !== e.l) begin
                        failures++;
                        $display("FAIL record: got (%0d,%0d) expected (%0d,%0d)", run_value, run_len, e.v, e.l);
                    end
                end
            end
        end
    end

    initial begin
        reset      = 1;
        item_in    = 0;
        item_valid = 0;
        flush      = 0;
        run_ready  = 0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_item_ready", int'(item_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_run_valid", int'(run_valid), 0);
        check("rst_run_value", int'(run_value), 0);
        check("rst_run_len", int'(run_len), 0);

        // 5,5,5,7 then flush
        run_ready = 1;
        step(1, 5, 0);
        step(1, 5, 0);
        step(1, 5, 0);
        check("t1_no_record_yet", int'(run_valid), 0);
        step(1, 7, 0);
        check("t1_rec_valid", int'(run_valid), 1);
        check("t1_rec_value", int'(run_value), 5);
        check("t1_rec_len", int'(run_len), 3);
        check("t1_busy", int'(busy), 1);
        step(0, 0, 1);
        check("t1_busy_after_flush", int'(busy), 0);
        check("t1_flush_value", int'(run_value), 7);
        check("t1_flush_len", int'(run_len), 1);
        flush = 0;
        drain();

        // incrementing stream
        for (int i = 0; i < 20; i++) step(1, i, 0);
        close_run();
        drain();

        // saturating run
        for (int i = 0; i < 256; i++) step(1, 8'hAA, 0);
        close_run();
        drain();

        // backpressure with alternating items
        run_ready = 0;
        step(1, 1, 0);
        step(1, 2, 0);
        step(1, 1, 0);
        step(1, 2, 0);
        check("bp_ready_3_pushes", int'(item_ready), 1);
        step(1, 1, 0);
        check("bp_ready_full", int'(item_ready), 0);
        step(1, 2, 0);
        check("bp_stalled", int'(item_ready), 0);
        check("bp_busy", int'(busy), 1);
        run_ready = 1;
        step(1, 2, 0);
        check("bp_ready_after_pop", int'(item_ready), 1);
        step(1, 2, 0);
        close_run();
        drain();

        // flush coincident with an accepted item
        step(1, 9, 0);
        step(1, 9, 0);
        step(1, 9, 1);
        check("fa_busy", int'(busy), 1);
        check("fa_no_push", int'(run_valid), 0);
        step(0, 0, 1);
        check("fa_busy_closed", int'(busy), 0);
        check("fa_len", int'(run_len), 3);
        flush = 0;
        drain();

        // reset mid-operation
        run_ready = 0;
        step(1, 1, 0);
        step(1, 2, 0);
        step(1, 3, 0);
        step(1, 3, 0);
        step(1, 3, 0);
        step(1, 3, 0);
        item_valid = 0;
        check("mr_valid_before", int'(run_valid), 1);
        do_reset();
        check("mr_run_valid", int'(run_valid), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_item_ready", int'(item_ready), 1);
        run_ready = 1;
        step(1, 4, 0);
        step(1, 4, 0);
        close_run();
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            run_ready = ($urandom_range(0, 9) < 7);
            step($urandom_range(0, 9) < 8, $urandom_range(0, 2), $urandom_range(0, 19) == 0);
        end
        item_valid = 0;
        close_run();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
